// File: rtl/branch_resolve_track.sv
// Carries tournament-predictor outputs ID->EX->MEM, resolves them in EX and
// produces per-component error feedback plus saturating branch statistics.
module branch_resolve_track #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stallE,
   input  logic             flushE,
   input  logic             flushM,
   input  logic             branchD,
   input  logic             pred_globalD,
   input  logic             pred_localD,
   input  logic             pred_chooseD,
   input  logic             actual_takenE,
   input  logic             cnt_clr,
   output logic             branchE,
   output logic             pred_takenE,
   output logic             pred_errorE,
   output logic             branchM,
   output logic             global_errorM,
   output logic             local_errorM,
   output logic             pred_errorM,
   output logic             actual_takenM,
   output logic [CNT_W-1:0] cnt_branch,
   output logic [CNT_W-1:0] cnt_mispred
);

   logic predGlobalE;
   logic predLocalE;
   logic predChooseE;

   // ID->EX: flush beats stall so a squashed instruction never lingers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         branchE     <= 1'b0;
         predGlobalE <= 1'b0;
         predLocalE  <= 1'b0;
         predChooseE <= 1'b0;
      end else if (flushE) begin
         branchE     <= 1'b0;
         predGlobalE <= 1'b0;
         predLocalE  <= 1'b0;
         predChooseE <= 1'b0;
      end else if (!stallE) begin
         branchE     <= branchD;
         predGlobalE <= pred_globalD;
         predLocalE  <= pred_localD;
         predChooseE <= pred_chooseD;
      end
   end

   assign pred_takenE = predChooseE ? predGlobalE : predLocalE;
   assign pred_errorE = branchE & (pred_takenE ^ actual_takenE);

   logic squashM;
   assign squashM = flushM | stallE;

   // A stalled EX branch sends bubbles forward so it reaches MEM exactly once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         branchM       <= 1'b0;
         global_errorM <= 1'b0;
         local_errorM  <= 1'b0;
         pred_errorM   <= 1'b0;
         actual_takenM <= 1'b0;
      end else if (squashM) begin
         branchM       <= 1'b0;
         global_errorM <= 1'b0;
         local_errorM  <= 1'b0;
         pred_errorM   <= 1'b0;
         actual_takenM <= 1'b0;
      end else begin
         branchM       <= branchE;
         global_errorM <= branchE & (predGlobalE ^ actual_takenE);
         local_errorM  <= branchE & (predLocalE ^ actual_takenE);
         pred_errorM   <= pred_errorE;
         actual_takenM <= branchE & actual_takenE;
      end
   end

   logic [CNT_W-1:0] cntMax;
   assign cntMax = '1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_branch  <= '0;
         cnt_mispred <= '0;
      end else if (cnt_clr) begin
         cnt_branch  <= '0;
         cnt_mispred <= '0;
      end else if (branchM) begin
         if (cnt_branch != cntMax) begin
            cnt_branch <= cnt_branch + 1'b1;
         end
         if (pred_errorM && (cnt_mispred != cntMax)) begin
            cnt_mispred <= cnt_mispred + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_branch_resolve_track.sv
// Directed bench for branch_resolve_track with 4-bit counters so saturation is reachable.
module tb_branch_resolve_track;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             stallE, flushE, flushM;
   logic             branchD, pred_globalD, pred_localD, pred_chooseD;
   logic             actual_takenE, cnt_clr;
   logic             branchE, pred_takenE, pred_errorE;
   logic             branchM, global_errorM, local_errorM, pred_errorM, actual_takenM;
   logic [CNT_W-1:0] cnt_branch, cnt_mispred;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   branch_resolve_track #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .stallE(stallE), .flushE(flushE), .flushM(flushM),
      .branchD(branchD), .pred_globalD(pred_globalD), .pred_localD(pred_localD),
      .pred_chooseD(pred_chooseD), .actual_takenE(actual_takenE), .cnt_clr(cnt_clr),
      .branchE(branchE), .pred_takenE(pred_takenE), .pred_errorE(pred_errorE),
      .branchM(branchM), .global_errorM(global_errorM), .local_errorM(local_errorM),
      .pred_errorM(pred_errorM), .actual_takenM(actual_takenM),
      .cnt_branch(cnt_branch), .cnt_mispred(cnt_mispred)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic setD(input logic b, input logic g, input logic l, input logic c);
      branchD      = b;
      pred_globalD = g;
      pred_localD  = l;
      pred_chooseD = c;
   endtask

   task automatic chkMem(input string tag, input logic b, input logic ge, input logic le,
                         input logic pe, input logic at);
      chk({tag, "_branchM"}, 32'(branchM), 32'(b));
      chk({tag, "_gerr"}, 32'(global_errorM), 32'(ge));
      chk({tag, "_lerr"}, 32'(local_errorM), 32'(le));
      chk({tag, "_perr"}, 32'(pred_errorM), 32'(pe));
      chk({tag, "_atM"}, 32'(actual_takenM), 32'(at));
   endtask

   task automatic chkCnt(input string tag, input int b, input int m);
      chk({tag, "_cntb"}, 32'(cnt_branch), 32'(b));
      chk({tag, "_cntm"}, 32'(cnt_mispred), 32'(m));
   endtask

   initial begin
      rst = 1'b0;
      stallE = 1'b0; flushE = 1'b0; flushM = 1'b0;
      setD(1'b0, 1'b0, 1'b0, 1'b0);
      actual_takenE = 1'b0; cnt_clr = 1'b0;
      #3;
      chk("rst_branchE", 32'(branchE), 32'd0);
      chk("rst_predTaken", 32'(pred_takenE), 32'd0);
      chkMem("rst", 0, 0, 0, 0, 0);
      chkCnt("rst", 0, 0);
      #4 rst = 1'b1;
      tick();

      // Correct taken branch via global predictor
      setD(1, 1, 0, 1);
      tick();
      setD(0, 0, 0, 0); actual_takenE = 1'b1;
      #1;
      chk("t1_branchE", 32'(branchE), 32'd1);
      chk("t1_predTaken", 32'(pred_takenE), 32'd1);
      chk("t1_predErr", 32'(pred_errorE), 32'd0);
      tick();
      chkMem("t1", 1, 0, 1, 0, 1);
      chkCnt("t1_mem", 0, 0);
      tick();
      chkMem("t1_after", 0, 0, 0, 0, 0);
      chkCnt("t1", 1, 0);

      // Local predictor chosen and wrong
      setD(1, 1, 0, 0);
      tick();
      setD(0, 0, 0, 0); actual_takenE = 1'b1;
      #1;
      chk("t2_predTaken", 32'(pred_takenE), 32'd0);
      chk("t2_predErr", 32'(pred_errorE), 32'd1);
      tick();
      chkMem("t2", 1, 0, 1, 1, 1);
      tick();
      chkCnt("t2", 2, 1);

      // EX stall held 3 cycles: branch reaches MEM exactly once
      setD(1, 0, 0, 0);
      tick();
      setD(0, 0, 0, 0); stallE = 1'b1; actual_takenE = 1'b0;
      #1;
      chk("t3_branchE0", 32'(branchE), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t3_branchE_held", 32'(branchE), 32'd1);
         chk("t3_branchM_bubble", 32'(branchM), 32'd0);
      end
      stallE = 1'b0;
      tick();
      chk("t3_branchE_gone", 32'(branchE), 32'd0);
      chkMem("t3", 1, 0, 0, 0, 0);
      tick();
      chk("t3_branchM_once", 32'(branchM), 32'd0);
      chkCnt("t3", 3, 1);

      // flushE beats stallE
      setD(1, 1, 1, 1); flushE = 1'b1; stallE = 1'b1;
      tick();
      setD(0, 0, 0, 0); flushE = 1'b0; stallE = 1'b0;
      #1;
      chk("t4_branchE", 32'(branchE), 32'd0);
      chk("t4_predTaken", 32'(pred_takenE), 32'd0);
      tick();
      chk("t4_branchM", 32'(branchM), 32'd0);
      tick();
      chkCnt("t4", 3, 1);

      // Non-branch with predictor fields: prediction visible, no error
      setD(0, 1, 0, 1);
      tick();
      setD(0, 0, 0, 0); actual_takenE = 1'b0;
      #1;
      chk("t5_predTaken", 32'(pred_takenE), 32'd1);
      chk("t5_predErr", 32'(pred_errorE), 32'd0);
      tick();
      chkMem("t5", 0, 0, 0, 0, 0);

      // flushM squashes a branch leaving EX
      setD(1, 1, 1, 1);
      tick();
      setD(0, 0, 0, 0); flushM = 1'b1; actual_takenE = 1'b0;
      tick();
      flushM = 1'b0;
      chkMem("t6", 0, 0, 0, 0, 0);
      tick();
      chkCnt("t6", 3, 1);

      // Saturation: clear, then 20 mispredicted branches back to back
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chkCnt("t7_clr", 0, 0);
      setD(1, 1, 1, 1); actual_takenE = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      setD(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) tick();
      chkCnt("t7_sat", 15, 15);

      // cnt_clr overrides an increment from a live MEM branch
      setD(1, 1, 1, 1);
      tick();
      setD(0, 0, 0, 0);
      tick();
      cnt_clr = 1'b1;
      #1;
      chk("t8_branchM", 32'(branchM), 32'd1);
      tick();
      cnt_clr = 1'b0;
      chkCnt("t8_clr", 0, 0);
      tick();
      chkCnt("t8_after", 0, 0);

      // Asynchronous reset with branches in EX and MEM
      setD(1, 1, 0, 1); actual_takenE = 1'b1;
      tick(); tick(); tick();
      chk("t9_pre_branchE", 32'(branchE), 32'd1);
      chk("t9_pre_branchM", 32'(branchM), 32'd1);
      chkCnt("t9_pre", 1, 0);
      rst = 1'b0;
      setD(0, 0, 0, 0);
      #1;
      chk("t9_branchE", 32'(branchE), 32'd0);
      chk("t9_predTaken", 32'(pred_takenE), 32'd0);
      chk("t9_predErr", 32'(pred_errorE), 32'd0);
      chkMem("t9", 0, 0, 0, 0, 0);
      chkCnt("t9", 0, 0);
      #1 rst = 1'b1;
      tick(); tick();
      chk("t9_rel_branchE", 32'(branchE), 32'd0);
      chkMem("t9_rel", 0, 0, 0, 0, 0);
      chkCnt("t9_rel", 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
